// File: rtl/actor_mover.sv
// actor_mover: sub-pixel accumulator and pixel-stepping mover that probes a
// 128x128 solid map along the hitbox leading edge, X axis first, then Y.
module actor_mover #(
   parameter int unsigned HB_W     = 6,
   parameter int unsigned HB_H     = 5,
   parameter int unsigned MAX_STEP = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic signed [15:0] pos_x_in,
   input  logic signed [15:0] pos_y_in,
   input  logic signed [31:0] rem_x_in,
   input  logic signed [31:0] rem_y_in,
   input  logic signed [31:0] spd_x,
   input  logic signed [31:0] spd_y,
   output logic               map_rd,
   output logic [6:0]         map_x,
   output logic [6:0]         map_y,
   input  logic               map_solid,
   output logic               busy,
   output logic               done,
   output logic signed [15:0] pos_x,
   output logic signed [15:0] pos_y,
   output logic signed [31:0] rem_x,
   output logic signed [31:0] rem_y,
   output logic               hit_x,
   output logic               hit_y
);

   localparam int unsigned     CW      = $clog2(MAX_STEP + 1);
   localparam logic [CW-1:0]   ONE_C   = CW'(1);
   localparam logic [4:0]      KX_LAST = 5'(HB_H - 1);
   localparam logic [4:0]      KY_LAST = 5'(HB_W - 1);
   localparam logic [15:0]     W16     = 16'(HB_W);
   localparam logic [15:0]     H16     = 16'(HB_H);

   typedef enum logic [2:0] {
      IDLE, ACCUM, X_ISSUE, X_CHECK, Y_ISSUE, Y_CHECK, DONE
   } state_t;

   state_t             state_q, state_d;
   logic [15:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic signed [31:0] rem_x_q, rem_x_d, rem_y_q, rem_y_d;
   logic signed [31:0] spd_x_q, spd_x_d, spd_y_q, spd_y_d;
   logic [CW-1:0]      cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
   logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;  // 1 = negative
   logic [4:0]         k_q, k_d;
   logic               hit_x_q, hit_x_d, hit_y_q, hit_y_d;

   logic signed [31:0] r_x, r_y, amt_x, amt_y;
   logic [CW-1:0]      c_x, c_y;
   logic [15:0]        k16, ex_col, ex_row, ey_col, ey_row;

   // Clamp |amt| to MAX_STEP.
   function automatic logic [CW-1:0] clamp_steps(input logic signed [31:0] amt);
      logic [31:0] mag;
      mag = amt[31] ? 32'(-amt) : 32'(amt);
      return (mag > 32'(MAX_STEP)) ? CW'(MAX_STEP) : mag[CW-1:0];
   endfunction

   // Negative coordinates collapse to address 0; otherwise wrap to 7 bits.
   function automatic logic [6:0] map_addr(input logic [15:0] c);
      return c[15] ? 7'd0 : c[6:0];
   endfunction

   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE);
   assign pos_x = pos_x_q;
   assign pos_y = pos_y_q;
   assign rem_x = rem_x_q;
   assign rem_y = rem_y_q;
   assign hit_x = hit_x_q;
   assign hit_y = hit_y_q;

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pos_x_q <= '0;  pos_y_q <= '0;
         rem_x_q <= '0;  rem_y_q <= '0;
         spd_x_q <= '0;  spd_y_q <= '0;
         cnt_x_q <= '0;  cnt_y_q <= '0;
         dir_x_q <= 1'b0; dir_y_q <= 1'b0;
         k_q     <= '0;
         hit_x_q <= 1'b0; hit_y_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_x_q <= pos_x_d;  pos_y_q <= pos_y_d;
         rem_x_q <= rem_x_d;  rem_y_q <= rem_y_d;
         spd_x_q <= spd_x_d;  spd_y_q <= spd_y_d;
         cnt_x_q <= cnt_x_d;  cnt_y_q <= cnt_y_d;
         dir_x_q <= dir_x_d;  dir_y_q <= dir_y_d;
         k_q     <= k_d;
         hit_x_q <= hit_x_d;  hit_y_q <= hit_y_d;
      end
   end

   // Next-state logic, accumulation, edge-probe addressing and step walking.
   always_comb begin
      state_d = state_q;
      pos_x_d = pos_x_q;  pos_y_d = pos_y_q;
      rem_x_d = rem_x_q;  rem_y_d = rem_y_q;
      spd_x_d = spd_x_q;  spd_y_d = spd_y_q;
      cnt_x_d = cnt_x_q;  cnt_y_d = cnt_y_q;
      dir_x_d = dir_x_q;  dir_y_d = dir_y_q;
      k_d     = k_q;
      hit_x_d = hit_x_q;  hit_y_d = hit_y_q;
      map_rd  = 1'b0;
      map_x   = '0;
      map_y   = '0;

      r_x   = rem_x_q + spd_x_q;
      r_y   = rem_y_q + spd_y_q;
      amt_x = (r_x + 32'sh8000) >>> 16;
      amt_y = (r_y + 32'sh8000) >>> 16;
      c_x   = clamp_steps(amt_x);
      c_y   = clamp_steps(amt_y);

      k16    = {11'd0, k_q};
      ex_col = dir_x_q ? (pos_x_q - 16'd1) : (pos_x_q + W16);
      ex_row = pos_y_q + k16;
      ey_row = dir_y_q ? (pos_y_q - 16'd1) : (pos_y_q + H16);
      ey_col = pos_x_q + k16;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               pos_x_d = pos_x_in;  pos_y_d = pos_y_in;
               rem_x_d = rem_x_in;  rem_y_d = rem_y_in;
               spd_x_d = spd_x;     spd_y_d = spd_y;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            // Remainder keeps the unclamped whole-pixel amount.
            rem_x_d = r_x - (amt_x <<< 16);
            rem_y_d = r_y - (amt_y <<< 16);
            cnt_x_d = c_x;  cnt_y_d = c_y;
            dir_x_d = amt_x[31];
            dir_y_d = amt_y[31];
            hit_x_d = 1'b0; hit_y_d = 1'b0;
            k_d     = '0;
            if (c_x != '0)      state_d = X_ISSUE;
            else if (c_y != '0) state_d = Y_ISSUE;
            else                state_d = DONE;
         end
         X_ISSUE: begin
            map_rd  = 1'b1;
            map_x   = map_addr(ex_col);
            map_y   = map_addr(ex_row);
            state_d = X_CHECK;
         end
         X_CHECK: begin
            if (map_solid) begin
               hit_x_d = 1'b1;
               rem_x_d = '0;
               cnt_x_d = '0;
               k_d     = '0;
               state_d = (cnt_y_q != '0) ? Y_ISSUE : DONE;
            end else if (k_q != KX_LAST) begin
               k_d     = k_q + 5'd1;
               state_d = X_ISSUE;
            end else begin
               pos_x_d = dir_x_q ? (pos_x_q - 16'd1) : (pos_x_q + 16'd1);
               cnt_x_d = cnt_x_q - ONE_C;
               k_d     = '0;
               if (cnt_x_q != ONE_C)    state_d = X_ISSUE;
               else if (cnt_y_q != '0)  state_d = Y_ISSUE;
               else                     state_d = DONE;
            end
         end
         Y_ISSUE: begin
            map_rd  = 1'b1;
            map_x   = map_addr(ey_col);
            map_y   = map_addr(ey_row);
            state_d = Y_CHECK;
         end
         Y_CHECK: begin
            if (map_solid) begin
               hit_y_d = 1'b1;
               rem_y_d = '0;
               cnt_y_d = '0;
               k_d     = '0;
               state_d = DONE;
            end else if (k_q != KY_LAST) begin
               k_d     = k_q + 5'd1;
               state_d = Y_ISSUE;
            end else begin
               pos_y_d = dir_y_q ? (pos_y_q - 16'd1) : (pos_y_q + 16'd1);
               cnt_y_d = cnt_y_q - ONE_C;
               k_d     = '0;
               state_d = (cnt_y_q != ONE_C) ? Y_ISSUE : DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_actor_mover.sv
// tb_actor_mover: directed and randomized moves against a behavioural
// per-pixel walking model with a 128x128 solid map.
module tb_actor_mover;

   localparam int HB_W     = 6;
   localparam int HB_H     = 5;
   localparam int MAX_STEP = 8;
   localparam int BOUND    = 400;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic signed [15:0] pos_x_in, pos_y_in;
   logic signed [31:0] rem_x_in, rem_y_in, spd_x, spd_y;
   logic               map_rd;
   logic [6:0]         map_x, map_y;
   logic               map_solid;
   logic               busy, done;
   logic signed [15:0] pos_x, pos_y;
   logic signed [31:0] rem_x, rem_y;
   logic               hit_x, hit_y;

   bit                 solid [128][128];
   logic [13:0]        exp_q [$];
   logic [15:0]        m_px, m_py;
   int                 e_rx, e_ry, e_probes, e_cyc;
   bit                 e_hx, e_hy;
   int                 checks = 0;
   int                 errors = 0;

   actor_mover #(.HB_W(HB_W), .HB_H(HB_H), .MAX_STEP(MAX_STEP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
      .rem_x_in(rem_x_in), .rem_y_in(rem_y_in),
      .spd_x(spd_x), .spd_y(spd_y),
      .map_rd(map_rd), .map_x(map_x), .map_y(map_y), .map_solid(map_solid),
      .busy(busy), .done(done),
      .pos_x(pos_x), .pos_y(pos_y), .rem_x(rem_x), .rem_y(rem_y),
      .hit_x(hit_x), .hit_y(hit_y)
   );

   always #5 clk = ~clk;

   // Solid-map read port: data is valid the cycle after the strobe.
   always @(posedge clk) begin
      map_solid <= map_rd ? solid[map_x][map_y] : 1'b0;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] amap(input logic [15:0] c);
      return c[15] ? 7'd0 : c[6:0];
   endfunction

   task automatic clear_map();
      for (int x = 0; x < 128; x++)
         for (int y = 0; y < 128; y++)
            solid[x][y] = 1'b0;
   endtask

   // Walk one axis pixel by pixel, probing every leading-edge pixel in order.
   task automatic model_axis(input bit is_x, input int amt);
      int n, dir, lim;
      bit h;
      logic [15:0] cx, cy;
      n   = (amt < 0) ? -amt : amt;
      if (n > MAX_STEP) n = MAX_STEP;
      dir = (amt < 0) ? -1 : 1;
      lim = is_x ? HB_H : HB_W;
      h   = 1'b0;
      for (int s = 0; s < n && !h; s++) begin
         for (int k = 0; k < lim && !h; k++) begin
            if (is_x) begin
               cx = (dir > 0) ? 16'(m_px + HB_W) : 16'(m_px - 1);
               cy = 16'(m_py + k);
            end else begin
               cy = (dir > 0) ? 16'(m_py + HB_H) : 16'(m_py - 1);
               cx = 16'(m_px + k);
            end
            exp_q.push_back({amap(cx), amap(cy)});
            e_probes++;
            if (solid[amap(cx)][amap(cy)]) h = 1'b1;
         end
         if (!h) begin
            if (is_x) m_px = 16'(m_px + dir);
            else      m_py = 16'(m_py + dir);
         end
      end
      if (is_x) begin e_hx = h; if (h) e_rx = 0; end
      else      begin e_hy = h; if (h) e_ry = 0; end
   endtask

   task automatic model_run(input logic [15:0] px, py, input int rx, ry, sx, sy);
      int ax, ay;
      exp_q.delete();
      e_probes = 0;
      m_px = px; m_py = py;
      e_rx = rx + sx;
      e_ry = ry + sy;
      ax   = (e_rx + 32768) >>> 16;
      ay   = (e_ry + 32768) >>> 16;
      e_rx = e_rx - ax * 65536;
      e_ry = e_ry - ay * 65536;
      model_axis(1'b1, ax);
      model_axis(1'b0, ay);
      e_cyc = 2 + 2 * e_probes;
   endtask

   task automatic run_move(input string tag, input logic [15:0] px, py,
                           input int rx, ry, sx, sy, input bit disturb);
      int cyc, n_rd;
      bit seen;
      logic [13:0] a;
      model_run(px, py, rx, ry, sx, sy);
      @(negedge clk);
      pos_x_in = px; pos_y_in = py;
      rem_x_in = rx; rem_y_in = ry;
      spd_x = sx;    spd_y = sy;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (disturb) begin
         pos_x_in = 16'($urandom); pos_y_in = 16'($urandom);
         rem_x_in = $urandom; rem_y_in = $urandom;
         spd_x = $urandom;    spd_y = $urandom;
      end
      cyc = 1; n_rd = 0; seen = 1'b0;
      while (!seen && cyc <= BOUND) begin
         check({tag, "_busy"}, 64'(busy), 64'd1);
         if (map_rd) begin
            n_rd++;
            if (exp_q.size() == 0) check({tag, "_extra_probe"}, 64'(n_rd), 64'(e_probes));
            else begin
               a = exp_q.pop_front();
               check({tag, "_probe_addr"}, 64'({map_x, map_y}), 64'(a));
            end
         end
         if (done) seen = 1'b1;
         else begin
            start = (disturb && cyc == 3) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      check({tag, "_done_cycle"}, 64'(cyc), 64'(e_cyc));
      check({tag, "_probes"}, 64'(n_rd), 64'(e_probes));
      check({tag, "_pos_x"}, 64'($unsigned(pos_x)), 64'(m_px));
      check({tag, "_pos_y"}, 64'($unsigned(pos_y)), 64'(m_py));
      check({tag, "_rem_x"}, 64'($unsigned(rem_x)), 64'($unsigned(e_rx)));
      check({tag, "_rem_y"}, 64'($unsigned(rem_y)), 64'($unsigned(e_ry)));
      check({tag, "_hits"}, 64'({hit_x, hit_y}), 64'({e_hx, e_hy}));
      @(negedge clk);
      check({tag, "_idle_after"}, 64'({busy, done}), 64'd0);
   endtask

   initial begin
      bit got;
      rst_n = 1'b0; start = 1'b0;
      pos_x_in = '0; pos_y_in = '0; rem_x_in = '0; rem_y_in = '0;
      spd_x = '0; spd_y = '0;
      clear_map();
      repeat (2) @(negedge clk);
      check("reset_ctrl", 64'({map_rd, busy, done, hit_x, hit_y}), 64'd0);
      check("reset_pos", 64'({pos_x, pos_y}), 64'd0);
      check("reset_rem", 64'({rem_x, rem_y}), 64'd0);
      rst_n = 1'b1;

      run_move("zero", 16'd40, 16'd40, 0, 0, 0, 0, 1'b0);
      run_move("round", 16'd40, 16'd40, 0, 0, 32'h0001_8000, 0, 1'b0);

      solid[17][22] = 1'b1;
      run_move("wall", 16'd10, 16'd20, 0, 0, 32'h0003_0000, 0, 1'b0);
      clear_map();

      solid[0][30] = 1'b1;
      run_move("negedge", 16'd0, 16'd30, 0, 0, 32'hFFFF_0000, 0, 1'b0);
      clear_map();

      run_move("clamp_y", 16'd50, 16'd50, 0, 0, 0, 32'h0014_0000, 1'b0);
      run_move("up_from0", 16'd50, 16'd0, 0, 0, 0, 32'hFFFF_0000, 1'b0);

      // Reset while the first X probe result is being checked.
      @(negedge clk);
      pos_x_in = 16'd60; pos_y_in = 16'd60; rem_x_in = 0; rem_y_in = 0;
      spd_x = 32'h0003_0000; spd_y = 0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (map_rd) got = 1'b1;
         else @(negedge clk);
      end
      check("rst_saw_issue", 64'(got), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_ctrl", 64'({map_rd, busy, done, hit_x, hit_y}), 64'd0);
      check("midrst_pos", 64'({pos_x, pos_y}), 64'd0);
      check("midrst_rem", 64'({rem_x, rem_y}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_no_done", 64'({busy, done}), 64'd0);
      run_move("after_rst", 16'd60, 16'd60, 0, 0, 32'h0003_0000, 32'h0001_0000, 1'b0);

      // Randomized moves over a sparse random map, with stray start pulses.
      for (int t = 0; t < 30; t++) begin
         for (int x = 0; x < 128; x++)
            for (int y = 0; y < 128; y++)
               solid[x][y] = ($urandom_range(0, 99) < 3);
         run_move("rand",
                  16'($signed($urandom_range(0, 133)) - 3),
                  16'($signed($urandom_range(0, 133)) - 3),
                  $signed($urandom_range(0, 131071)) - 65536,
                  $signed($urandom_range(0, 131071)) - 65536,
                  $signed($urandom_range(0, 24 * 65536)) - 12 * 65536,
                  $signed($urandom_range(0, 24 * 65536)) - 12 * 65536,
                  1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
